// File: rtl/vga_timing_pkg.sv
// Shared types and sizing helpers for the VGA raster timing generator.
// Optional runtime sync polarity is enabled by VGA_TIMING_RUNTIME_POL_EN.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } vga_phase_t;

  // Total period of one axis in pixels or lines
  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width for a given total, never narrower than one bit
  function automatic int unsigned vga_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with ACTIVE/FP/SYNC/BP phase tracking.
// Used for both horizontal (steps per pixel) and vertical (steps per line wrap).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter  int unsigned ACTIVE = 640,
  parameter  int unsigned FP     = 16,
  parameter  int unsigned SYNC   = 96,
  parameter  int unsigned BP     = 48,
  localparam int unsigned TOTAL  = vga_total(ACTIVE, FP, SYNC, BP),
  localparam int unsigned W      = vga_width(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_i,
  output logic [W-1:0] count_o,
  output vga_phase_t   phase_o,
  output logic         wrap_c_o
);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_param_err
    $error("vga_axis_counter: ACTIVE, FP, SYNC and BP must all be >= 1");
  end

  localparam logic [W-1:0] END_ACTIVE = W'(ACTIVE - 1);
  localparam logic [W-1:0] END_FP     = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] END_SYNC   = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] END_TOTAL  = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;
  vga_phase_t   phase_q, phase_d;

  assign wrap_c_o = step_i && (cnt_q == END_TOTAL);

  // Phase register tracks the counter; it advances on the last count of each phase
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (step_i) begin
      cnt_d = (cnt_q == END_TOTAL) ? '0 : cnt_q + W'(1);
      unique case (phase_q)
        PH_ACTIVE: if (cnt_q == END_ACTIVE) phase_d = PH_FP;
        PH_FP:     if (cnt_q == END_FP)     phase_d = PH_SYNC;
        PH_SYNC:   if (cnt_q == END_SYNC)   phase_d = PH_BP;
        PH_BP:     if (cnt_q == END_TOTAL)  phase_d = PH_ACTIVE;
        default:                            phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign count_o = cnt_q;
  assign phase_o = phase_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: x/y, data-enable, polarity-corrected syncs and frame strobes.
// Define VGA_TIMING_RUNTIME_POL_EN to add frame-synchronous hpol_i/vpol_i inputs.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter  int unsigned H_ACTIVE = 640,
  parameter  int unsigned H_FP     = 16,
  parameter  int unsigned H_SYNC   = 96,
  parameter  int unsigned H_BP     = 48,
  parameter  int unsigned V_ACTIVE = 480,
  parameter  int unsigned V_FP     = 10,
  parameter  int unsigned V_SYNC   = 2,
  parameter  int unsigned V_BP     = 33,
  parameter  bit          HPOL     = 1'b0,
  parameter  bit          VPOL     = 1'b0,
  localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned XW       = vga_width(H_TOTAL),
  localparam int unsigned YW       = vga_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
`ifdef VGA_TIMING_RUNTIME_POL_EN
  input  logic          hpol_i,
  input  logic          vpol_i,
`endif
  output logic          pix_valid,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  vga_phase_t    h_phase, v_phase;
  logic          h_wrap_c;
  logic          v_wrap_unused_c;
  logic          line_emit_c, frame_emit_c;
  logic          hpol_c, vpol_c;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (en),
    .count_o (hcnt),
    .phase_o (h_phase),
    .wrap_c_o(h_wrap_c)
  );

  // Vertical axis advances once per completed line
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (h_wrap_c),
    .count_o (vcnt),
    .phase_o (v_phase),
    .wrap_c_o(v_wrap_unused_c)
  );

  assign line_emit_c  = en && (hcnt == '0);
  assign frame_emit_c = line_emit_c && (vcnt == '0);

`ifdef VGA_TIMING_RUNTIME_POL_EN
  logic hpol_q, vpol_q;

  // New polarity takes effect from the frame_start pixel onward, never mid-frame
  assign hpol_c = frame_emit_c ? hpol_i : hpol_q;
  assign vpol_c = frame_emit_c ? vpol_i : vpol_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpol_q <= HPOL;
      vpol_q <= VPOL;
    end else if (frame_emit_c) begin
      hpol_q <= hpol_i;
      vpol_q <= vpol_i;
    end
  end
`else
  assign hpol_c = HPOL;
  assign vpol_c = VPOL;
`endif

  logic          pix_valid_q, de_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          de_d, hsync_d, vsync_d;

  assign de_d    = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign hsync_d = (h_phase == PH_SYNC) ? hpol_c : ~hpol_c;
  assign vsync_d = (v_phase == PH_SYNC) ? vpol_c : ~vpol_c;

  // Emit the current position; pixel outputs hold while en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HPOL;
      vsync_q       <= ~VPOL;
    end else begin
      pix_valid_q   <= en;
      line_start_q  <= line_emit_c;
      frame_start_q <= frame_emit_c;
      if (en) begin
        x_q     <= hcnt;
        y_q     <= vcnt;
        de_q    <= de_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on an 8x6 raster (H 4/1/2/1, V 3/1/1/1).
module tb_vga_timing_ctrl;

  localparam bit TB_HPOL = 1'b0;
  localparam bit TB_VPOL = 1'b1;

  typedef struct packed {
    logic       pv;
    logic [2:0] px;
    logic [2:0] py;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       hpol_i;
  logic       vpol_i;
  logic       pix_valid;
  logic [2:0] x;
  logic [2:0] y;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HPOL(TB_HPOL), .VPOL(TB_VPOL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
`ifdef VGA_TIMING_RUNTIME_POL_EN
    .hpol_i     (hpol_i),
    .vpol_i     (vpol_i),
`endif
    .pix_valid  (pix_valid),
    .x          (x),
    .y          (y),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t last;
  int   mx, my;
  logic m_hpol, m_vpol;
  bit   cont_mode, have_fs;
  int   cyc_since_fs, de_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx     = 0;
    my     = 0;
    m_hpol = TB_HPOL;
    m_vpol = TB_VPOL;
    last   = '{pv: 1'b0, px: 3'd0, py: 3'd0, de: 1'b0, hs: ~TB_HPOL, vs: ~TB_VPOL,
               ls: 1'b0, fs: 1'b0};
    have_fs = 1'b0;
  endtask

  task automatic check_outputs(input exp_t ex);
    chk("pix_valid",   32'(pix_valid),   32'(ex.pv));
    chk("x",           32'(x),           32'(ex.px));
    chk("y",           32'(y),           32'(ex.py));
    chk("de",          32'(de),          32'(ex.de));
    chk("hsync",       32'(hsync),       32'(ex.hs));
    chk("vsync",       32'(vsync),       32'(ex.vs));
    chk("line_start",  32'(line_start),  32'(ex.ls));
    chk("frame_start", 32'(frame_start), 32'(ex.fs));
  endtask

  // Called at a negedge: drive en, predict, compare after the edge, return at next negedge
  task automatic step(input logic e);
    exp_t ex;
    en = e;
    if (e) begin
`ifdef VGA_TIMING_RUNTIME_POL_EN
      if (mx == 0 && my == 0) begin
        m_hpol = hpol_i;
        m_vpol = vpol_i;
      end
`endif
      ex.pv = 1'b1;
      ex.px = 3'(mx);
      ex.py = 3'(my);
      ex.de = (mx < 4) && (my < 3);
      ex.hs = (mx == 5 || mx == 6) ? m_hpol : ~m_hpol;
      ex.vs = (my == 4) ? m_vpol : ~m_vpol;
      ex.ls = (mx == 0);
      ex.fs = (mx == 0) && (my == 0);
      mx = (mx == 7) ? 0 : mx + 1;
      if (mx == 0) my = (my == 5) ? 0 : my + 1;
      last = ex;
    end else begin
      ex    = last;
      ex.pv = 1'b0;
      ex.ls = 1'b0;
      ex.fs = 1'b0;
    end
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      ex = sb.pop_front();
      check_outputs(ex);
    end
    if (cont_mode) begin
      cyc_since_fs++;
      if (frame_start) begin
        if (have_fs) begin
          chk("fs_period",    32'(cyc_since_fs), 32'd48);
          chk("de_per_frame", 32'(de_cnt),       32'd12);
        end
        have_fs      = 1'b1;
        cyc_since_fs = 0;
        de_cnt       = 0;
      end
      if (pix_valid && de) de_cnt++;
    end
    @(negedge clk);
  endtask

  // One reset clock from a negedge, with reset-state checks, back at a negedge
  task automatic reset_pulse(input logic e_during);
    rst_n = 1'b0;
    en    = e_during;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs(last);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    rst_n        = 1'b0;
    en           = 1'b0;
    hpol_i       = TB_HPOL;
    vpol_i       = TB_VPOL;
    cont_mode    = 1'b0;
    cyc_since_fs = 0;
    de_cnt       = 0;
    model_reset();

    @(negedge clk);
    for (int i = 0; i < 3; i++) reset_pulse(1'b0);

    // Continuous enable over two full frames plus a bit
    cont_mode = 1'b1;
    for (int i = 0; i < 100; i++) step(1'b1);
    cont_mode = 1'b0;

    // Gapped enable: 1,0,0,1 pattern
    for (int i = 0; i < 15; i++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b1);
    end

    // Seek to emitted position (6,2), then reset mid-frame
    guard = 0;
    while (!(last.px == 3'd6 && last.py == 3'd2 && last.pv) && guard < 100) begin
      step(1'b1);
      guard++;
    end
    chk("seek_6_2_timeout", 32'(guard >= 100), 32'd0);
    reset_pulse(1'b1);
    for (int i = 0; i < 20; i++) step(1'b1);

`ifdef VGA_TIMING_RUNTIME_POL_EN
    // Flip hsync polarity mid-frame; effective only from the next frame_start
    hpol_i = 1'b1;
    for (int i = 0; i < 110; i++) step(1'b1);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
